write_channel_router: RTL and testbench

WRITE_CHANNEL_ROUTER -- requirements
Module: write_channel_router

---
 rtl/write_channel_router_pkg.sv | 22 ++
 rtl/write_channel_router_if.sv | 57 +++++
 rtl/write_channel_router.sv | 114 +++++++++++
 tb/tb_write_channel_router.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/write_channel_router_pkg.sv
// Shared AXI widths, select/response encodings and router FSM states.
package write_channel_router_pkg;
    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = 4;
    localparam int AXI_LEN_BITS  = 4;

    localparam logic [1:0] SEL_S0  = 2'b00;
    localparam logic [1:0] SEL_S1  = 2'b01;
    localparam logic [1:0] SEL_DEF = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_WRESP} state_t;

    // Slave IDs carry the master ID in their upper bits.
    function automatic logic [AXI_ID_BITS-1:0] master_bid(input logic [AXI_IDS_BITS-1:0] sid);
        return sid[AXI_IDS_BITS-1 -: AXI_ID_BITS];
    endfunction
endpackage

// File: rtl/write_channel_router_if.sv
// AW/W/B signal bundle between arbiter/decoder, master and the two slaves.
interface write_channel_router_if;
    import write_channel_router_pkg::*;

    logic [AXI_ID_BITS-1:0]   AWID_ARB;
    logic [AXI_LEN_BITS-1:0]  AWLEN_ARB;
    logic                     AWVALID_ARB;
    logic [1:0]               AW_S;
    logic                     AWREADY_M1;
    logic                     AWREADY_DEF;
    logic                     AW_lock_reg;

    logic [AXI_DATA_BITS-1:0] WDATA_M1;
    logic [AXI_STRB_BITS-1:0] WSTRB_M1;
    logic                     WVALID_M1, WREADY_M1;

    logic [AXI_DATA_BITS-1:0] WDATA_S0, WDATA_S1;
    logic [AXI_STRB_BITS-1:0] WSTRB_S0, WSTRB_S1;
    logic                     WLAST_S0, WLAST_S1, WVALID_S0, WVALID_S1;
    logic                     WREADY_S0, WREADY_S1;

    logic [AXI_IDS_BITS-1:0]  BID_S0, BID_S1;
    logic [1:0]               BRESP_S0, BRESP_S1;
    logic                     BVALID_S0, BVALID_S1, BREADY_S0, BREADY_S1;

    logic [AXI_ID_BITS-1:0]   BID_M1;
    logic [1:0]               BRESP_M1;
    logic                     BVALID_M1, BREADY_M1;

    // Router side.
    modport slave (
        input  AWID_ARB, AWLEN_ARB, AWVALID_ARB, AW_S, AWREADY_M1,
        output AWREADY_DEF, AW_lock_reg,
        input  WDATA_M1, WSTRB_M1, WVALID_M1,
        output WREADY_M1,
        output WDATA_S0, WDATA_S1, WSTRB_S0, WSTRB_S1, WLAST_S0, WLAST_S1, WVALID_S0, WVALID_S1,
        input  WREADY_S0, WREADY_S1,
        input  BID_S0, BID_S1, BRESP_S0, BRESP_S1, BVALID_S0, BVALID_S1,
        output BREADY_S0, BREADY_S1,
        output BID_M1, BRESP_M1, BVALID_M1,
        input  BREADY_M1
    );

    // Environment side (arbiter, decoder, master, slaves).
    modport master (
        output AWID_ARB, AWLEN_ARB, AWVALID_ARB, AW_S, AWREADY_M1,
        input  AWREADY_DEF, AW_lock_reg,
        output WDATA_M1, WSTRB_M1, WVALID_M1,
        input  WREADY_M1,
        input  WDATA_S0, WDATA_S1, WSTRB_S0, WSTRB_S1, WLAST_S0, WLAST_S1, WVALID_S0, WVALID_S1,
        output WREADY_S0, WREADY_S1,
        output BID_S0, BID_S1, BRESP_S0, BRESP_S1, BVALID_S0, BVALID_S1,
        input  BREADY_S0, BREADY_S1,
        input  BID_M1, BRESP_M1, BVALID_M1,
        output BREADY_M1
    );
endinterface

// File: rtl/write_channel_router.sv
// Single-outstanding write router: locks on AW, steers W beats to S0/S1 or sinks
// them for the default slave, then returns that slave's (or a DECERR) B response.
module write_channel_router
    import write_channel_router_pkg::*;
(
    input  logic                  ACLK,
    input  logic                  ARESET,
    write_channel_router_if.slave bus
);
    state_t                  r_state;
    logic [1:0]              r_sel;
    logic [AXI_ID_BITS-1:0]  r_id;
    logic [AXI_LEN_BITS-1:0] r_len;
    logic [AXI_LEN_BITS-1:0] r_cnt;

    logic w_aw_fire, w_beat, w_b_fire, w_last;

    assign w_last    = (r_cnt == r_len);
    assign w_aw_fire = (r_state == ST_IDLE) && bus.AWVALID_ARB && (bus.AWREADY_M1 || bus.AWREADY_DEF);
    assign w_beat    = (r_state == ST_WDATA) && bus.WVALID_M1 && bus.WREADY_M1;
    assign w_b_fire  = (r_state == ST_WRESP) && bus.BVALID_M1 && bus.BREADY_M1;

    assign bus.AW_lock_reg = (r_state != ST_IDLE);

    // Everything is held at zero while reset is asserted, even mid-burst.
    always_comb begin
        bus.AWREADY_DEF = 1'b0;
        bus.WREADY_M1   = 1'b0;
        bus.WDATA_S0    = '0;
        bus.WDATA_S1    = '0;
        bus.WSTRB_S0    = '0;
        bus.WSTRB_S1    = '0;
        bus.WLAST_S0    = 1'b0;
        bus.WLAST_S1    = 1'b0;
        bus.WVALID_S0   = 1'b0;
        bus.WVALID_S1   = 1'b0;
        bus.BREADY_S0   = 1'b0;
        bus.BREADY_S1   = 1'b0;
        bus.BID_M1      = '0;
        bus.BRESP_M1    = RESP_OKAY;
        bus.BVALID_M1   = 1'b0;
        if (!ARESET) begin
            bus.AWREADY_DEF = (r_state == ST_IDLE) && bus.AWVALID_ARB && (bus.AW_S == SEL_DEF);
            if (r_state == ST_WDATA) begin
                case (r_sel)
                    SEL_S0: begin
                        bus.WDATA_S0  = bus.WDATA_M1;
                        bus.WSTRB_S0  = bus.WSTRB_M1;
                        bus.WVALID_S0 = bus.WVALID_M1;
                        bus.WLAST_S0  = w_last;
                        bus.WREADY_M1 = bus.WREADY_S0;
                    end
                    SEL_S1: begin
                        bus.WDATA_S1  = bus.WDATA_M1;
                        bus.WSTRB_S1  = bus.WSTRB_M1;
                        bus.WVALID_S1 = bus.WVALID_M1;
                        bus.WLAST_S1  = w_last;
                        bus.WREADY_M1 = bus.WREADY_S1;
                    end
                    // Unmapped target: accept and drop every beat.
                    default: bus.WREADY_M1 = 1'b1;
                endcase
            end
            if (r_state == ST_WRESP) begin
                case (r_sel)
                    SEL_S0: begin
                        bus.BVALID_M1 = bus.BVALID_S0;
                        bus.BRESP_M1  = bus.BRESP_S0;
                        bus.BID_M1    = master_bid(bus.BID_S0);
                        bus.BREADY_S0 = bus.BREADY_M1;
                    end
                    SEL_S1: begin
                        bus.BVALID_M1 = bus.BVALID_S1;
                        bus.BRESP_M1  = bus.BRESP_S1;
                        bus.BID_M1    = master_bid(bus.BID_S1);
                        bus.BREADY_S1 = bus.BREADY_M1;
                    end
                    default: begin
                        bus.BVALID_M1 = 1'b1;
                        bus.BRESP_M1  = RESP_DECERR;
                        bus.BID_M1    = r_id;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_aw_fire) begin
                    r_sel   <= bus.AW_S;
                    r_id    <= bus.AWID_ARB;
                    r_len   <= bus.AWLEN_ARB;
                    r_cnt   <= '0;
                    r_state <= ST_WDATA;
                end
                // Counter stops at len so a 16-beat burst never wraps it.
                ST_WDATA: if (w_beat) begin
                    if (w_last) r_state <= ST_WRESP;
                    else        r_cnt   <= r_cnt + 4'd1;
                end
                ST_WRESP: if (w_b_fire) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_write_channel_router.sv
// Randomized bench: every cycle compares all router outputs with a transaction-level model.
module tb_write_channel_router;
    import write_channel_router_pkg::*;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    write_channel_router_if bus ();
    write_channel_router dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 = no transaction, 1 = collecting beats, 2 = awaiting response.
    int         m_phase   = 0;
    logic [1:0] m_sel     = 2'b00;
    logic [3:0] m_id      = 4'h0;
    int         m_done    = 0;
    int         m_nbeats  = 0;
    int         m_accepts = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic rand_inputs();
        bus.AWID_ARB    = 4'($urandom);
        bus.AWLEN_ARB   = 4'($urandom);
        bus.AWVALID_ARB = 1'($urandom);
        bus.AW_S        = 2'($urandom_range(0, 2));
        bus.AWREADY_M1  = (bus.AW_S != SEL_DEF) && 1'($urandom);
        bus.WDATA_M1    = $urandom;
        bus.WSTRB_M1    = 4'($urandom);
        bus.WVALID_M1   = 1'($urandom);
        bus.WREADY_S0   = 1'($urandom);
        bus.WREADY_S1   = 1'($urandom);
        bus.BID_S0      = 8'($urandom);
        bus.BID_S1      = 8'($urandom);
        bus.BRESP_S0    = 2'($urandom);
        bus.BRESP_S1    = 2'($urandom);
        bus.BVALID_S0   = 1'($urandom);
        bus.BVALID_S1   = 1'($urandom);
        bus.BREADY_M1   = 1'($urandom);
    endtask

    // Inputs are already driven (just after a falling edge); check, advance model, wait next falling edge.
    task automatic step();
        logic w_on, b_on, to0, to1, e_last, e_wready, e_bvalid;
        logic [1:0] e_bresp;
        logic [3:0] e_bid;
        #2;
        w_on   = !ARESET && (m_phase == 1);
        b_on   = !ARESET && (m_phase == 2);
        to0    = (m_sel == 2'b00);
        to1    = (m_sel == 2'b01);
        e_last = (m_done == m_nbeats - 1);
        e_wready = w_on && (to0 ? bus.WREADY_S0 : to1 ? bus.WREADY_S1 : 1'b1);
        e_bvalid = b_on && (to0 ? bus.BVALID_S0 : to1 ? bus.BVALID_S1 : 1'b1);
        e_bresp  = !b_on ? 2'b00 : to0 ? bus.BRESP_S0 : to1 ? bus.BRESP_S1 : 2'b11;
        e_bid    = !b_on ? 4'h0 : to0 ? 4'(bus.BID_S0 / 16) : to1 ? 4'(bus.BID_S1 / 16) : m_id;

        chk("awready_def", bus.AWREADY_DEF,
            !ARESET && m_phase == 0 && bus.AWVALID_ARB && bus.AW_S == 2'b10);
        chk("aw_lock", bus.AW_lock_reg, m_phase != 0);
        chk("wready_m1", bus.WREADY_M1, e_wready);
        chk("wdata_s0",  bus.WDATA_S0,  (w_on && to0) ? bus.WDATA_M1 : 32'h0);
        chk("wstrb_s0",  bus.WSTRB_S0,  (w_on && to0) ? bus.WSTRB_M1 : 4'h0);
        chk("wvalid_s0", bus.WVALID_S0, w_on && to0 && bus.WVALID_M1);
        chk("wlast_s0",  bus.WLAST_S0,  w_on && to0 && e_last);
        chk("wdata_s1",  bus.WDATA_S1,  (w_on && to1) ? bus.WDATA_M1 : 32'h0);
        chk("wstrb_s1",  bus.WSTRB_S1,  (w_on && to1) ? bus.WSTRB_M1 : 4'h0);
        chk("wvalid_s1", bus.WVALID_S1, w_on && to1 && bus.WVALID_M1);
        chk("wlast_s1",  bus.WLAST_S1,  w_on && to1 && e_last);
        chk("bvalid_m1", bus.BVALID_M1, e_bvalid);
        chk("bresp_m1",  bus.BRESP_M1,  e_bresp);
        chk("bid_m1",    bus.BID_M1,    e_bid);
        chk("bready_s0", bus.BREADY_S0, b_on && to0 && bus.BREADY_M1);
        chk("bready_s1", bus.BREADY_S1, b_on && to1 && bus.BREADY_M1);

        if (ARESET) begin
            m_phase = 0; m_sel = 2'b00; m_id = 4'h0; m_done = 0; m_nbeats = 0;
        end else if (m_phase == 0) begin
            if (bus.AWVALID_ARB && (bus.AWREADY_M1 || bus.AW_S == 2'b10)) begin
                m_sel = bus.AW_S; m_id = bus.AWID_ARB;
                m_nbeats = int'(bus.AWLEN_ARB) + 1; m_done = 0;
                m_phase = 1; m_accepts++;
            end
        end else if (m_phase == 1) begin
            if (bus.WVALID_M1 && e_wready) begin
                m_done++;
                if (m_done == m_nbeats) m_phase = 2;
            end
        end else if (e_bvalid && bus.BREADY_M1) begin
            m_phase = 0;
        end
        @(negedge ACLK);
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && m_phase != 0; c++) begin
            rand_inputs();
            ARESET = 1'b0;
            bus.AWVALID_ARB = 1'b0;
            bus.WVALID_M1 = 1'b1; bus.WREADY_S0 = 1'b1; bus.WREADY_S1 = 1'b1;
            bus.BVALID_S0 = 1'b1; bus.BVALID_S1 = 1'b1; bus.BREADY_M1 = 1'b1;
            step();
        end
        chk("drain_lock", bus.AW_lock_reg, 1'b0);
    endtask

    // wr_mode: 0 = all ready, 1 = slave WREADY toggles, other = random.
    task automatic run_txn(input logic [1:0] aws, input logic [3:0] len, input logic [3:0] id,
                           input logic [7:0] bid, input int wr_mode, input int b_delay, input bit aw_hold);
        int  start_acc;
        int  b_wait = 0;
        bit  done = 1'b0;
        drain();
        start_acc = m_accepts;
        for (int c = 0; c < 80 && !done; c++) begin
            rand_inputs();
            ARESET = 1'b0;
            if (m_accepts == start_acc || aw_hold) begin
                bus.AW_S = aws; bus.AWID_ARB = id; bus.AWLEN_ARB = len;
                bus.AWVALID_ARB = 1'b1; bus.AWREADY_M1 = (aws != SEL_DEF);
            end
            if (wr_mode == 0) begin
                bus.WVALID_M1 = 1'b1; bus.WREADY_S0 = 1'b1; bus.WREADY_S1 = 1'b1;
            end else if (wr_mode == 1) begin
                bus.WVALID_M1 = 1'b1; bus.WREADY_S0 = c[0]; bus.WREADY_S1 = c[0];
            end
            bus.BID_S0 = bid; bus.BID_S1 = bid;
            bus.BVALID_S0 = 1'b1; bus.BVALID_S1 = 1'b1;
            if (m_phase == 2) begin
                bus.BREADY_M1 = (b_wait >= b_delay);
                b_wait++;
            end
            step();
            done = aw_hold ? (m_accepts >= start_acc + 2) : (m_accepts > start_acc && m_phase == 0);
        end
        chk("txn_done", done, 1'b1);
        drain();
    endtask

    initial begin
        int acc0;
        rand_inputs();
        bus.AWVALID_ARB = 1'b0;
        ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        rand_inputs();
        ARESET = 1'b1;
        step();
        chk("reset_lock", bus.AW_lock_reg, 1'b0);

        run_txn(SEL_S0,  4'd3, 4'h3, 8'h30, 0, 0, 1'b0);
        run_txn(SEL_S1,  4'd1, 4'h9, 8'hA7, 1, 0, 1'b0);
        run_txn(SEL_DEF, 4'd2, 4'h5, 8'h00, 2, 2, 1'b0);
        run_txn(SEL_S1,  4'd0, 4'hC, 8'h5C, 0, 3, 1'b1);
        run_txn(SEL_DEF, 4'd1, 4'h6, 8'h00, 0, 3, 1'b1);
        run_txn(SEL_S0,  4'd15, 4'hE, 8'hE1, 2, 1, 1'b0);

        // Reset after the second beat of a 4-beat burst.
        drain();
        acc0 = m_accepts;
        for (int c = 0; c < 20 && !(m_phase == 1 && m_done == 2); c++) begin
            rand_inputs();
            ARESET = 1'b0;
            bus.AWVALID_ARB = (m_accepts == acc0);
            bus.AW_S = SEL_S0; bus.AWLEN_ARB = 4'd3; bus.AWREADY_M1 = 1'b1;
            bus.WVALID_M1 = 1'b1; bus.WREADY_S0 = 1'b1;
            step();
        end
        rand_inputs();
        ARESET = 1'b1;
        bus.AWVALID_ARB = 1'b0;
        step();
        chk("rst_mid_lock", bus.AW_lock_reg, 1'b0);
        rand_inputs();
        ARESET = 1'b0;
        bus.AWVALID_ARB = 1'b0;
        step();
        run_txn(SEL_S0, 4'd0, 4'h2, 8'h21, 0, 0, 1'b0);

        for (int c = 0; c < 700; c++) begin
            rand_inputs();
            ARESET = ($urandom_range(0, 63) == 0);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
